// File: rtl/instr_mem_loader.sv
// ----------------------------------------------------------------------------
// instr_mem_loader
//   Writer side of the instruction-memory interface. Receives a byte stream
//   (LEN_hi, LEN_lo, then LEN 16-bit words, high byte first) over a
//   valid/ready handshake. Each assembled word is written to the next
//   consecutive instruction-memory address, starting at BASE_ADDR. The
//   processor is held while a load is in progress.
//
// Ports
//   clk           system clock, rising edge
//   RESET         asynchronous, active-high reset
//   start         begin a load (honoured only in IDLE or DONE)
//   in_data       stream byte
//   in_valid      in_data is valid
//   in_ready      loader accepts a byte this cycle
//   mem_we        instruction-memory write strobe, one cycle per word
//   mem_addr      write word address
//   mem_wdata     write data
//   cpu_hold      processor hold while loading
//   done          load finished (level)
//   err           length rejected (valid when done=1)
//   words_loaded  words written in the current load
// ----------------------------------------------------------------------------
module instr_mem_loader #(
    parameter int ADDR_W    = 12,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              RESET,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [15:0]       words_loaded
);

    // Largest length that still fits between BASE_ADDR and the top of memory.
    localparam logic [16:0] MAX_LEN = 17'((32'd1 << ADDR_W) - 32'(BASE_ADDR));

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA_HI,
        DATA_LO,
        WRITE,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [15:0]         len_q, len_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [15:0]         wdata_q, wdata_d;
    logic [15:0]         count_q, count_d;
    logic                err_q, err_d;
    logic                xfer;

    // Handshake-facing and status outputs decode straight from the state, so
    // an asynchronous reset drops mem_we and cpu_hold in the same instant.
    assign in_ready     = (state_q == LEN_HI) || (state_q == LEN_LO) ||
                          (state_q == DATA_HI) || (state_q == DATA_LO);
    assign mem_we       = (state_q == WRITE);
    assign cpu_hold     = (state_q != IDLE) && (state_q != DONE);
    assign done         = (state_q == DONE);
    assign err          = err_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign words_loaded = count_q;

    assign xfer = in_valid && in_ready;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves a value unassigned, which would otherwise infer a latch.
        state_d = state_q;
        len_d   = len_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        count_d = count_q;
        err_d   = err_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = LEN_HI;
                    err_d   = 1'b0;
                    count_d = '0;
                    addr_d  = ADDR_W'(BASE_ADDR);
                end
            end
            LEN_HI: begin
                if (xfer) begin
                    len_d[15:8] = in_data;
                    state_d     = LEN_LO;
                end
            end
            LEN_LO: begin
                if (xfer) begin
                    len_d = {len_q[15:8], in_data};
                    if (len_d == 16'd0) begin
                        state_d = DONE;
                    end else if ({1'b0, len_d} > MAX_LEN) begin
                        // Rejecting oversize images here is what keeps the
                        // write address from ever wrapping.
                        state_d = DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = DATA_HI;
                    end
                end
            end
            DATA_HI: begin
                if (xfer) begin
                    wdata_d[15:8] = in_data;
                    state_d       = DATA_LO;
                end
            end
            DATA_LO: begin
                if (xfer) begin
                    wdata_d[7:0] = in_data;
                    state_d      = WRITE;
                end
            end
            WRITE: begin
                addr_d  = addr_q + ADDR_W'(1);
                count_d = count_q + 16'd1;
                state_d = (count_d == len_q) ? DONE : DATA_HI;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            len_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// ----------------------------------------------------------------------------
// tb_instr_mem_loader
//   Directed bench for instr_mem_loader. Two instances share the clock and
//   reset: the default 12-bit-address loader and a 4-bit-address loader for
//   the length-limit cases. Stimulus pushes the expected writes into a queue;
//   a monitor per instance pops and compares on every mem_we pulse.
// ----------------------------------------------------------------------------
module tb_instr_mem_loader;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;

    logic        start, in_valid, in_ready, mem_we, cpu_hold, done, err;
    logic [7:0]  in_data;
    logic [11:0] mem_addr;
    logic [15:0] mem_wdata, words_loaded;

    logic        start_s, in_valid_s, in_ready_s, mem_we_s, cpu_hold_s, done_s, err_s;
    logic [7:0]  in_data_s;
    logic [3:0]  mem_addr_s;
    logic [15:0] mem_wdata_s, words_loaded_s;

    wr_t exp_q[$];
    wr_t exp_s_q[$];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instr_mem_loader #(.ADDR_W(12), .BASE_ADDR(0)) dut (
        .clk(clk), .RESET(rst), .start(start), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_hold(cpu_hold),
        .done(done), .err(err), .words_loaded(words_loaded)
    );

    instr_mem_loader #(.ADDR_W(4), .BASE_ADDR(0)) dut_s (
        .clk(clk), .RESET(rst), .start(start_s), .in_data(in_data_s),
        .in_valid(in_valid_s), .in_ready(in_ready_s), .mem_we(mem_we_s),
        .mem_addr(mem_addr_s), .mem_wdata(mem_wdata_s), .cpu_hold(cpu_hold_s),
        .done(done_s), .err(err_s), .words_loaded(words_loaded_s)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitors: sample on the falling edge, away from updates.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL main_unexpected_write: addr 0x%0h data 0x%0h, no write expected",
                         mem_addr, mem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("main_wr_addr", 32'(mem_addr), 32'(e.addr));
                check("main_wr_data", 32'(mem_wdata), 32'(e.data));
            end
        end
    end

    always @(negedge clk) begin
        if (mem_we_s === 1'b1) begin
            if (exp_s_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL small_unexpected_write: addr 0x%0h data 0x%0h, no write expected",
                         mem_addr_s, mem_wdata_s);
            end else begin
                wr_t e;
                e = exp_s_q.pop_front();
                check("small_wr_addr", 32'(mem_addr_s), 32'(e.addr));
                check("small_wr_data", 32'(mem_wdata_s), 32'(e.data));
            end
        end
    end

    function automatic logic get_ready(input bit sel);
        return sel ? in_ready_s : in_ready;
    endfunction

    function automatic logic get_done(input bit sel);
        return sel ? done_s : done;
    endfunction

    task automatic drive(input bit sel, input logic v, input logic [7:0] d);
        if (sel) begin
            in_valid_s = v;
            in_data_s  = d;
        end else begin
            in_valid = v;
            in_data  = d;
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the byte
    // transferred. in_valid is left high afterwards.
    task automatic send_byte(input bit sel, input logic [7:0] b, input int gap);
        int n = 0;
        if (gap > 0) begin
            drive(sel, 1'b0, b);
            repeat (gap) @(negedge clk);
        end
        drive(sel, 1'b1, b);
        while (!get_ready(sel) && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (n >= 64) begin
            checks++;
            failures++;
            $display("FAIL in_ready_timeout: byte 0x%0h not accepted within 64 cycles", b);
        end else begin
            @(negedge clk);
        end
    endtask

    task automatic pulse_start(input bit sel);
        if (sel) start_s = 1'b1; else start = 1'b1;
        @(negedge clk);
        if (sel) start_s = 1'b0; else start = 1'b0;
    endtask

    task automatic wait_done(input bit sel);
        int n = 0;
        while (!get_done(sel) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: done not seen within 500 cycles (sel=%0d)", sel);
        end
    endtask

    task automatic push_main(input logic [15:0] a, input logic [15:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic push_small(input logic [15:0] a, input logic [15:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_s_q.push_back(e);
    endtask

    logic [7:0] s1[8] = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h0F, 8'h0F};
    int         g4[8] = '{0, 2, 1, 0, 3, 1, 2, 0};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        start_s = 1'b0; in_valid_s = 1'b0; in_data_s = 8'h00;
        repeat (2) @(negedge clk);

        // Reset values
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_mem_wdata", 32'(mem_wdata), 0);
        check("rst_cpu_hold", 32'(cpu_hold), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_words", 32'(words_loaded), 0);
        check("rst_s_in_ready", 32'(in_ready_s), 0);
        check("rst_s_done", 32'(done_s), 0);
        rst = 1'b0;
        @(negedge clk);

        // Case 1: three words, in_valid held high
        push_main(16'd0, 16'h1234);
        push_main(16'd1, 16'hABCD);
        push_main(16'd2, 16'h0F0F);
        pulse_start(1'b0);
        check("c1_start_hold", 32'(cpu_hold), 1);
        check("c1_start_ready", 32'(in_ready), 1);
        check("c1_start_done", 32'(done), 0);
        for (int i = 0; i < 8; i++) send_byte(1'b0, s1[i], 0);
        check("c1_write_we", 32'(mem_we), 1);
        check("c1_write_ready", 32'(in_ready), 0);
        check("c1_write_addr", 32'(mem_addr), 2);
        @(negedge clk);
        check("c1_done", 32'(done), 1);
        check("c1_words", 32'(words_loaded), 3);
        check("c1_hold_released", 32'(cpu_hold), 0);
        check("c1_err", 32'(err), 0);
        check("c1_done_ready", 32'(in_ready), 0);
        repeat (3) @(negedge clk);
        check("c1_done_persists", 32'(done), 1);
        check("c1_pending", 32'(exp_q.size()), 0);

        // Case 2: zero-length image
        drive(1'b0, 1'b0, 8'h00);
        pulse_start(1'b0);
        check("c2_done_cleared", 32'(done), 0);
        check("c2_words_cleared", 32'(words_loaded), 0);
        send_byte(1'b0, 8'h00, 0);
        send_byte(1'b0, 8'h00, 0);
        check("c2_done", 32'(done), 1);
        check("c2_err", 32'(err), 0);
        check("c2_hold", 32'(cpu_hold), 0);
        check("c2_words", 32'(words_loaded), 0);
        repeat (2) @(negedge clk);

        // Case 4: case 1 stream with in_valid gaps
        drive(1'b0, 1'b0, 8'h00);
        push_main(16'd0, 16'h1234);
        push_main(16'd1, 16'hABCD);
        push_main(16'd2, 16'h0F0F);
        pulse_start(1'b0);
        for (int i = 0; i < 8; i++) send_byte(1'b0, s1[i], g4[i]);
        wait_done(1'b0);
        check("c4_words", 32'(words_loaded), 3);
        check("c4_addr_end", 32'(mem_addr), 3);
        check("c4_pending", 32'(exp_q.size()), 0);

        // Case 6: start pulses during DATA_HI are ignored
        drive(1'b0, 1'b0, 8'h00);
        push_main(16'd0, 16'h1111);
        push_main(16'd1, 16'h2222);
        pulse_start(1'b0);
        send_byte(1'b0, 8'h00, 0);
        send_byte(1'b0, 8'h02, 0);
        drive(1'b0, 1'b0, 8'h00);
        pulse_start(1'b0);
        check("c6_a_addr", 32'(mem_addr), 0);
        check("c6_a_words", 32'(words_loaded), 0);
        check("c6_a_ready", 32'(in_ready), 1);
        check("c6_a_hold", 32'(cpu_hold), 1);
        send_byte(1'b0, 8'h11, 0);
        send_byte(1'b0, 8'h11, 0);
        drive(1'b0, 1'b0, 8'h00);
        @(negedge clk);
        pulse_start(1'b0);
        check("c6_b_addr", 32'(mem_addr), 1);
        check("c6_b_words", 32'(words_loaded), 1);
        check("c6_b_ready", 32'(in_ready), 1);
        send_byte(1'b0, 8'h22, 0);
        send_byte(1'b0, 8'h22, 0);
        wait_done(1'b0);
        check("c6_words", 32'(words_loaded), 2);
        check("c6_err", 32'(err), 0);
        check("c6_pending", 32'(exp_q.size()), 0);

        // Case 5: reset during DATA_LO of word 2
        drive(1'b0, 1'b0, 8'h00);
        push_main(16'd0, 16'h1234);
        pulse_start(1'b0);
        for (int i = 0; i < 5; i++) send_byte(1'b0, s1[i], 0);
        drive(1'b0, 1'b0, 8'h00);
        check("c5_pre_hold", 32'(cpu_hold), 1);
        rst = 1'b1;
        #1;
        check("c5_rst_in_ready", 32'(in_ready), 0);
        check("c5_rst_mem_we", 32'(mem_we), 0);
        check("c5_rst_addr", 32'(mem_addr), 0);
        check("c5_rst_wdata", 32'(mem_wdata), 0);
        check("c5_rst_hold", 32'(cpu_hold), 0);
        check("c5_rst_done", 32'(done), 0);
        check("c5_rst_err", 32'(err), 0);
        check("c5_rst_words", 32'(words_loaded), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("c5_idle_done", 32'(done), 0);
        check("c5_pending_after_rst", 32'(exp_q.size()), 0);
        push_main(16'd0, 16'h5566);
        pulse_start(1'b0);
        send_byte(1'b0, 8'h00, 0);
        send_byte(1'b0, 8'h01, 0);
        send_byte(1'b0, 8'h55, 0);
        send_byte(1'b0, 8'h66, 0);
        wait_done(1'b0);
        check("c5_reload_words", 32'(words_loaded), 1);
        check("c5_reload_addr_end", 32'(mem_addr), 1);
        check("c5_reload_pending", 32'(exp_q.size()), 0);

        // Case 3: ADDR_W=4, len=17 rejected
        pulse_start(1'b1);
        send_byte(1'b1, 8'h00, 0);
        send_byte(1'b1, 8'h11, 0);
        check("c3_done", 32'(done_s), 1);
        check("c3_err", 32'(err_s), 1);
        check("c3_ready", 32'(in_ready_s), 0);
        check("c3_hold", 32'(cpu_hold_s), 0);
        check("c3_words", 32'(words_loaded_s), 0);
        repeat (2) @(negedge clk);
        check("c3_ready_later", 32'(in_ready_s), 0);

        // ADDR_W=4, len=16 is the largest accepted image
        drive(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 16; i++) begin
            logic [7:0] b;
            b = 8'(i);
            push_small(16'(i), {b, ~b});
        end
        pulse_start(1'b1);
        check("c3b_err_cleared", 32'(err_s), 0);
        send_byte(1'b1, 8'h00, 0);
        send_byte(1'b1, 8'h10, 0);
        for (int i = 0; i < 16; i++) begin
            logic [7:0] b;
            b = 8'(i);
            send_byte(1'b1, b, 0);
            send_byte(1'b1, ~b, 0);
        end
        wait_done(1'b1);
        check("c3b_err", 32'(err_s), 0);
        check("c3b_words", 32'(words_loaded_s), 16);
        check("c3b_pending", 32'(exp_s_q.size()), 0);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
